// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, buffers returned words for decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_fault and halt fetching.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_fault
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DISC = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr;
    logic [PW-1:0]         r_rd;
    logic [31:0]           r_buf_instr [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] r_buf_pc    [BUF_DEPTH];

    logic [ADDR_WIDTH-1:0] w_redir_pc;
    logic                  w_fault;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;
    logic w_misalign;
    assign w_redir_pc = redirect_pc;
    assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_fault    = r_fault;

    always_ff @(posedge clk) begin
        if (rst)             r_fault <= 1'b0;
        else if (w_misalign) r_fault <= 1'b1;
    end
`else
    assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);
    assign w_fault    = 1'b0;
`endif

    assign w_issue = !rst && !redirect && !w_fault && (r_state == S_IDLE) && (r_count < DEPTH_C);
    assign w_push  = !redirect && (r_state == S_WAIT) && imem_rvalid;
    assign w_pop   = !redirect && instr_valid && instr_ready;

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_buf_instr[r_rd] : 32'h0;
    assign instr_pc    = instr_valid ? r_buf_pc[r_rd] : '0;
    assign fetch_fault = w_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_count    <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_count    <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            // a response landing in the redirect cycle retires the outstanding request
            if (r_state != S_IDLE)
                r_state <= imem_rvalid ? S_IDLE : S_DISC;
        end else begin
            case (r_state)
                S_IDLE: if (w_issue) begin
                    r_state    <= S_WAIT;
                    r_req_pc   <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                end
                S_WAIT:  if (imem_rvalid) r_state <= S_IDLE;
                S_DISC:  if (imem_rvalid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
        end
    end

    // storage needs no reset: outputs are gated by the occupancy count
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_buf_instr[r_wr] <= imem_rdata;
            r_buf_pc[r_wr]    <= r_req_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle vectors plus a randomized run against a program-order model.
module tb_instr_fetch_unit;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif
    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D4 = 32'h0010_0093;
    localparam logic [31:0] D8 = 32'h0020_0113;
    localparam logic [31:0] DX = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    typedef struct {
        logic        r, rv, rdy, rdr, chk, e_req, e_val, e_flt;
        logic [31:0] rdata, rpc, e_addr, e_pc, e_ins;
    } vec_t;
    vec_t tv[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, rv, input logic [31:0] rdata, input logic rdy, rdr,
                       input logic [31:0] rpc, input logic chk, e_req, input logic [31:0] e_addr,
                       input logic e_val, input logic [31:0] e_pc, e_ins, input logic e_flt);
        vec_t v;
        v.r = r; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.chk = chk; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
        v.e_pc = e_pc; v.e_ins = e_ins; v.e_flt = e_flt;
        tv.push_back(v);
    endtask

    task automatic add_rst();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        pend, prev_redir, r_rst, rdy, rdr, rv;
        logic [31:0] pend_addr, exp_fetch, exp_cons, rpc;
        int          resp_cyc, n_cons;

        // latency 1, always ready
        add_rst();
        add(0, 0, 0,  1, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0);
        add(0, 1, D0, 1, 0, 0, 1, 0, 0,     0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0, 1, 1, 32'h4, 1, 32'h0, D0, 0);
        add(0, 1, D4, 1, 0, 0, 1, 0, 0,     0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0, 1, 1, 32'h8, 1, 32'h4, D4, 0);
        add(0, 1, D8, 1, 0, 0, 1, 0, 0,     0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0, 1, 1, 32'hC, 1, 32'h8, D8, 0);
        // decode stalled: buffer fills, one pop frees exactly one fetch
        add_rst();
        add(0, 0, 0,  0, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0);
        add(0, 1, D0, 0, 0, 0, 1, 0, 0,     0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0, 1, 1, 32'h4, 1, 32'h0, D0, 0);
        add(0, 1, D4, 0, 0, 0, 1, 0, 0,     1, 32'h0, D0, 0);
        add(0, 0, 0,  0, 0, 0, 1, 0, 0,     1, 32'h0, D0, 0);
        add(0, 0, 0,  1, 0, 0, 1, 0, 0,     1, 32'h0, D0, 0);
        add(0, 0, 0,  0, 0, 0, 1, 1, 32'h8, 1, 32'h4, D4, 0);
        add(0, 0, 0,  0, 0, 0, 1, 0, 0,     1, 32'h4, D4, 0);
        add(0, 1, D8, 0, 0, 0, 1, 0, 0,     1, 32'h4, D4, 0);
        add(0, 0, 0,  0, 0, 0, 1, 0, 0,     1, 32'h4, D4, 0);
        // redirect while waiting, latency 3: old response discarded
        add_rst();
        add(0, 0, 0,  0, 0, 0,      1, 1, 32'h0,   0, 0, 0, 0);
        add(0, 0, 0,  0, 1, 32'h100, 1, 0, 0,      0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,      1, 0, 0,       0, 0, 0, 0);
        add(0, 1, D0, 0, 0, 0,      1, 0, 0,       0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,      1, 1, 32'h100, 0, 0, 0, 0);
        add(0, 1, DX, 0, 0, 0,      1, 0, 0,       0, 0, 0, 0);
        add(0, 0, 0,  1, 0, 0,      1, 1, 32'h104, 1, 32'h100, DX, 0);
        // redirect coincident with rvalid and a pop
        add_rst();
        add(0, 0, 0,  0, 0, 0,       1, 1, 32'h0,   0, 0, 0, 0);
        add(0, 1, D0, 0, 0, 0,       1, 0, 0,       0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,       1, 1, 32'h4,   1, 32'h0, D0, 0);
        add(0, 1, D4, 1, 1, 32'h200, 1, 0, 0,       1, 32'h0, D0, 0);
        add(0, 0, 0,  0, 0, 0,       1, 1, 32'h200, 0, 0, 0, 0);
        // PC wrap at top of address space
        add_rst();
        add(0, 0, 0,  0, 1, 32'hFFFF_FFFC, 1, 0, 0,            0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        add(0, 1, D0, 0, 0, 0,             1, 0, 0,            0, 0, 0, 0);
        add(0, 0, 0,  0, 0, 0,             1, 1, 32'h0,        1, 32'hFFFF_FFFC, D0, 0);
        // misaligned redirect target
        add_rst();
        add(0, 0, 0,  0, 1, 32'h102, 1, 0,    0,       0,    0,       0,  0);
        add(0, 0, 0,  0, 0, 0,       1, !MIS, 32'h100, 0,    0,       0,  MIS);
        add(0, 1, DX, 0, 0, 0,       1, 0,    0,       0,    0,       0,  MIS);
        add(0, 0, 0,  0, 0, 0,       1, !MIS, 32'h104, !MIS, 32'h100, DX, MIS);
        add_rst();
        add(0, 0, 0,  0, 0, 0,       1, 1,    32'h0,   0,    0,       0,  0);

        repeat (2) @(negedge clk);
        #1;
        chk32("reset_req", {31'b0, imem_req}, 32'd0);
        chk32("reset_addr", imem_addr, 32'h0);
        chk32("reset_valid", {31'b0, instr_valid}, 32'd0);
        chk32("reset_instr", instr, 32'h0);
        chk32("reset_instr_pc", instr_pc, 32'h0);
        chk32("reset_fault", {31'b0, fetch_fault}, 32'd0);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst = tv[i].r; imem_rvalid = tv[i].rv; imem_rdata = tv[i].rdata;
            instr_ready = tv[i].rdy; redirect = tv[i].rdr; redirect_pc = tv[i].rpc;
            #1;
            chk32($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
            if (tv[i].chk) begin
                chk32($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tv[i].e_val});
                chk32($sformatf("vec%0d_fault", i), {31'b0, fetch_fault}, {31'b0, tv[i].e_flt});
                if (tv[i].e_req) chk32($sformatf("vec%0d_addr", i), imem_addr, tv[i].e_addr);
                if (tv[i].e_val) begin
                    chk32($sformatf("vec%0d_pc", i), instr_pc, tv[i].e_pc);
                    chk32($sformatf("vec%0d_instr", i), instr, tv[i].e_ins);
                end
            end
        end

        // randomized run: fetch stream and delivered stream must follow program order from the last redirect
        @(negedge clk);
        rst = 1'b1; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        pend = 1'b0; prev_redir = 1'b0; exp_fetch = 32'h0; exp_cons = 32'h0;
        pend_addr = 32'h0; resp_cyc = 0; n_cons = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_rst = ($urandom_range(0, 299) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            rdr   = !r_rst && ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_FFFF);
            if (MIS) rpc = rpc & ~32'h3;
            rv = pend && (c == resp_cyc);
            rst = r_rst; instr_ready = rdy; redirect = rdr; redirect_pc = rpc;
            imem_rvalid = rv; imem_rdata = rv ? mem(pend_addr) : $urandom;
            #1;
            chk32("rnd_fault", {31'b0, fetch_fault}, 32'd0);
            if (r_rst) begin
                chk32("rnd_rst_req", {31'b0, imem_req}, 32'd0);
                pend = 1'b0; exp_fetch = 32'h0; exp_cons = 32'h0; prev_redir = 1'b0;
                continue;
            end
            if (prev_redir) chk32("rnd_flush_valid", {31'b0, instr_valid}, 32'd0);
            if (rdr) chk32("rnd_redir_req", {31'b0, imem_req}, 32'd0);
            else if (imem_req) begin
                chk32("rnd_one_outstanding", {31'b0, pend}, 32'd0);
                chk32("rnd_addr", imem_addr, exp_fetch);
            end
            if (instr_valid && rdy && !rdr) begin
                chk32("rnd_pc", instr_pc, exp_cons);
                chk32("rnd_instr", instr, mem(exp_cons));
                exp_cons = exp_cons + 32'd4;
                n_cons++;
            end
            if (rv) pend = 1'b0;
            if (imem_req && !rdr) begin
                pend = 1'b1; pend_addr = exp_fetch; resp_cyc = c + $urandom_range(1, 4);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (rdr) begin
                exp_fetch = rpc & ~32'h3;
                exp_cons  = rpc & ~32'h3;
            end
            prev_redir = rdr;
        end
        chk32("rnd_progress", {31'b0, (n_cons > 200)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
